// File: rtl/rob_commit_scheduler_if.sv
// rob_commit_scheduler_if: dispatcher, CDB, register-file and flush signals of the ROB controller
// master: dispatcher/CDB side (drives dp_alloc_req, dp_rd, cdb_*), observes grants, commits and flushes
// slave : ROB controller side (drives dp_alloc_ok, dp_rob_index, rf_*, fl_*, rob_count)
interface rob_commit_scheduler_if #(
    parameter int ROB_WIDTH    = 4,
    parameter int EX_ROB_WIDTH = 5,
    parameter int EX_REG_WIDTH = 6
);
    logic                    dp_alloc_req;
    logic [EX_REG_WIDTH-1:0] dp_rd;
    logic                    dp_alloc_ok;
    logic [EX_ROB_WIDTH-1:0] dp_rob_index;
    logic                    rf_dep_en;
    logic [EX_REG_WIDTH-1:0] rf_dep_rd;
    logic [EX_ROB_WIDTH-1:0] rf_dep_index;
    logic                    cdb_en;
    logic [ROB_WIDTH-1:0]    cdb_index;
    logic [31:0]             cdb_value;
    logic                    cdb_mispred;
    logic [31:0]             cdb_target;
    logic                    rf_commit_en;
    logic [ROB_WIDTH-1:0]    rf_commit_index;
    logic [31:0]             rf_commit_value;
    logic [EX_REG_WIDTH-1:0] rf_commit_rd;
    logic                    rf_pre_judge;
    logic                    fl_en;
    logic [31:0]             fl_pc;
    logic [ROB_WIDTH:0]      rob_count;

    modport master (
        output dp_alloc_req, dp_rd, cdb_en, cdb_index, cdb_value, cdb_mispred, cdb_target,
        input  dp_alloc_ok, dp_rob_index, rf_dep_en, rf_dep_rd, rf_dep_index,
               rf_commit_en, rf_commit_index, rf_commit_value, rf_commit_rd,
               rf_pre_judge, fl_en, fl_pc, rob_count
    );
    modport slave (
        input  dp_alloc_req, dp_rd, cdb_en, cdb_index, cdb_value, cdb_mispred, cdb_target,
        output dp_alloc_ok, dp_rob_index, rf_dep_en, rf_dep_rd, rf_dep_index,
               rf_commit_en, rf_commit_index, rf_commit_value, rf_commit_rd,
               rf_pre_judge, fl_en, fl_pc, rob_count
    );
endinterface

// File: rtl/rob_commit_scheduler.sv
// rob_commit_scheduler: in-order ROB that allocates tags, collects CDB results and retires one entry per cycle
// clk_in : clock
// rst_in : asynchronous active-low reset
// rdy_in : global enable, low freezes every register
// bus    : dispatcher alloc/rename, CDB writeback, RF commit, flush/redirect and occupancy
module rob_commit_scheduler #(
    parameter int ROB_WIDTH    = 4,
    parameter int EX_ROB_WIDTH = 5,
    parameter int EX_REG_WIDTH = 6,
    parameter int NON_REG      = 32,
    parameter int NON_DEP      = 16
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    rob_commit_scheduler_if.slave bus
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0]      FULL   = {1'b1, {ROB_WIDTH{1'b0}}};
    localparam logic [EX_REG_WIDTH-1:0] NO_RD  = EX_REG_WIDTH'(NON_REG);
    localparam logic [EX_ROB_WIDTH-1:0] NO_DEP = EX_ROB_WIDTH'(NON_DEP);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                  state;
    logic [ROB_WIDTH-1:0]    head, tail;
    logic [ROB_WIDTH:0]      count;
    logic [DEPTH-1:0]        valid, ready, mispred;
    logic [EX_REG_WIDTH-1:0] rd_q     [DEPTH];
    logic [31:0]             value_q  [DEPTH];
    logic [31:0]             target_q [DEPTH];
    logic                    alloc, commit, flush, wb;

    assign bus.dp_alloc_ok  = state == RUN && count < FULL;
    assign bus.dp_rob_index = EX_ROB_WIDTH'(tail);
    assign alloc            = bus.dp_alloc_req && bus.dp_alloc_ok;
    assign bus.rf_dep_en    = alloc && bus.dp_rd != NO_RD && bus.dp_rd != '0;
    assign bus.rf_dep_rd    = bus.dp_rd;
    // the rename tag reads as "no dependency" whenever no rename is written
    assign bus.rf_dep_index = bus.rf_dep_en ? EX_ROB_WIDTH'(tail) : NO_DEP;
    assign commit           = state == RUN && valid[head] && ready[head];
    assign flush            = commit && mispred[head];
    assign wb               = bus.cdb_en && valid[bus.cdb_index];
    assign bus.rob_count    = count;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state               <= RUN;
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            valid               <= '0;
            ready               <= '0;
            mispred             <= '0;
            bus.rf_commit_en    <= 1'b0;
            bus.rf_commit_index <= '0;
            bus.rf_commit_value <= '0;
            bus.rf_commit_rd    <= NO_RD;
            bus.rf_pre_judge    <= 1'b1;
            bus.fl_en           <= 1'b0;
            bus.fl_pc           <= '0;
        end else if (rdy_in) begin
            bus.rf_commit_en <= 1'b0;
            bus.rf_pre_judge <= 1'b1;
            bus.fl_en        <= 1'b0;
            if (state == FLUSH) begin
                state <= RUN;
            end else if (flush) begin
                // a mispredicted head wins over any same-edge alloc or writeback
                valid            <= '0;
                head             <= '0;
                tail             <= '0;
                count            <= '0;
                bus.rf_pre_judge <= 1'b0;
                bus.fl_en        <= 1'b1;
                bus.fl_pc        <= target_q[head];
                state            <= FLUSH;
            end else begin
                if (wb) begin
                    ready[bus.cdb_index]   <= 1'b1;
                    mispred[bus.cdb_index] <= bus.cdb_mispred;
                end
                if (alloc) begin
                    valid[tail] <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + 1'b1;
                end
                if (commit) begin
                    bus.rf_commit_en    <= 1'b1;
                    bus.rf_commit_index <= head;
                    bus.rf_commit_value <= value_q[head];
                    bus.rf_commit_rd    <= rd_q[head];
                    valid[head]         <= 1'b0;
                    head                <= head + 1'b1;
                end
                if (alloc && !commit)
                    count <= count + 1'b1;
                else if (!alloc && commit)
                    count <= count - 1'b1;
            end
        end
    end

    // payload storage needs no reset: it is only read behind a valid/ready entry
    always_ff @(posedge clk_in) begin
        if (rdy_in && state == RUN && !flush) begin
            if (wb) begin
                value_q[bus.cdb_index]  <= bus.cdb_value;
                target_q[bus.cdb_index] <= bus.cdb_target;
            end
            if (alloc)
                rd_q[tail] <= bus.dp_rd;
        end
    end
endmodule

// File: tb/tb_rob_commit_scheduler.sv
// tb_rob_commit_scheduler: directed table-driven bench for rob_commit_scheduler
module tb_rob_commit_scheduler;
    logic clk, rst_n, rdy;
    int   checks, errors;

    rob_commit_scheduler_if #(.ROB_WIDTH(4), .EX_ROB_WIDTH(5), .EX_REG_WIDTH(6)) bus ();

    rob_commit_scheduler #(
        .ROB_WIDTH(4), .EX_ROB_WIDTH(5), .EX_REG_WIDTH(6), .NON_REG(32), .NON_DEP(16)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .rdy_in(rdy),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        req;
        logic [5:0]  rd;
        logic        ce;
        logic [3:0]  ci;
        logic [31:0] cv;
        logic        cm;
        logic [31:0] ct;
        logic        rdy;
        logic        e_ok;
        logic [4:0]  e_idx;
        logic        e_dep;
        logic        e_cen;
        logic [5:0]  e_crd;
        logic [31:0] e_cval;
        logic [3:0]  e_cidx;
        logic        e_pj;
        logic        e_fl;
        logic [31:0] e_flpc;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic req, input logic [5:0] rd,
        input logic ce, input logic [3:0] ci, input logic [31:0] cv, input logic cm, input logic [31:0] ct,
        input logic r,
        input logic e_ok, input logic [4:0] e_idx, input logic e_dep,
        input logic e_cen, input logic [5:0] e_crd, input logic [31:0] e_cval, input logic [3:0] e_cidx,
        input logic e_pj, input logic e_fl, input logic [31:0] e_flpc, input logic [4:0] e_cnt);
        vec_t v;
        v.req = req; v.rd = rd; v.ce = ce; v.ci = ci; v.cv = cv; v.cm = cm; v.ct = ct; v.rdy = r;
        v.e_ok = e_ok; v.e_idx = e_idx; v.e_dep = e_dep;
        v.e_cen = e_cen; v.e_crd = e_crd; v.e_cval = e_cval; v.e_cidx = e_cidx;
        v.e_pj = e_pj; v.e_fl = e_fl; v.e_flpc = e_flpc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string tag, input string f, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: actual=0x%0h required=0x%0h", tag, f, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        bus.dp_alloc_req = v.req;
        bus.dp_rd        = v.rd;
        bus.cdb_en       = v.ce;
        bus.cdb_index    = v.ci;
        bus.cdb_value    = v.cv;
        bus.cdb_mispred  = v.cm;
        bus.cdb_target   = v.ct;
        rdy              = v.rdy;
        #1;
        chk(tag, "dp_alloc_ok", bus.dp_alloc_ok, v.e_ok);
        chk(tag, "dp_rob_index", bus.dp_rob_index, v.e_idx);
        chk(tag, "rf_dep_en", bus.rf_dep_en, v.e_dep);
        if (v.e_dep) begin
            chk(tag, "rf_dep_rd", bus.rf_dep_rd, v.rd);
            chk(tag, "rf_dep_index", bus.rf_dep_index, v.e_idx);
        end
        @(posedge clk);
        #1;
        chk(tag, "rf_commit_en", bus.rf_commit_en, v.e_cen);
        if (v.e_cen) begin
            chk(tag, "rf_commit_rd", bus.rf_commit_rd, v.e_crd);
            chk(tag, "rf_commit_value", bus.rf_commit_value, v.e_cval);
            chk(tag, "rf_commit_index", bus.rf_commit_index, v.e_cidx);
        end
        chk(tag, "rf_pre_judge", bus.rf_pre_judge, v.e_pj);
        chk(tag, "fl_en", bus.fl_en, v.e_fl);
        if (v.e_fl) chk(tag, "fl_pc", bus.fl_pc, v.e_flpc);
        chk(tag, "rob_count", bus.rob_count, v.e_cnt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        rdy    = 1'b1;
        bus.dp_alloc_req = 1'b0;
        bus.dp_rd        = '0;
        bus.cdb_en       = 1'b0;
        bus.cdb_index    = '0;
        bus.cdb_value    = '0;
        bus.cdb_mispred  = 1'b0;
        bus.cdb_target   = '0;

        //                 req rd   ce ci cv        cm ct       rdy ok idx dep cen crd val      cidx pj fl flpc     cnt
        tbl.push_back(mk(1, 5,  0, 0, 0,        0, 0,       1,  1, 0, 1,  0, 0, 0,       0,  1, 0, 0,       1));
        tbl.push_back(mk(0, 0,  1, 0, 'h1234,   0, 0,       1,  1, 1, 0,  0, 0, 0,       0,  1, 0, 0,       1));
        tbl.push_back(mk(0, 0,  0, 0, 0,        0, 0,       1,  1, 1, 0,  1, 5, 'h1234,  0,  1, 0, 0,       0));
        tbl.push_back(mk(0, 0,  0, 0, 0,        0, 0,       1,  1, 1, 0,  0, 0, 0,       0,  1, 0, 0,       0));
        tbl.push_back(mk(1, 1,  0, 0, 0,        0, 0,       1,  1, 1, 1,  0, 0, 0,       0,  1, 0, 0,       1));
        tbl.push_back(mk(1, 2,  0, 0, 0,        0, 0,       1,  1, 2, 1,  0, 0, 0,       0,  1, 0, 0,       2));
        tbl.push_back(mk(1, 3,  0, 0, 0,        0, 0,       1,  1, 3, 1,  0, 0, 0,       0,  1, 0, 0,       3));
        tbl.push_back(mk(0, 0,  1, 3, 'h33,     0, 0,       1,  1, 4, 0,  0, 0, 0,       0,  1, 0, 0,       3));
        tbl.push_back(mk(0, 0,  1, 2, 'h22,     0, 0,       1,  1, 4, 0,  0, 0, 0,       0,  1, 0, 0,       3));
        tbl.push_back(mk(0, 0,  1, 1, 'h11,     0, 0,       1,  1, 4, 0,  0, 0, 0,       0,  1, 0, 0,       3));
        tbl.push_back(mk(0, 0,  0, 0, 0,        0, 0,       1,  1, 4, 0,  1, 1, 'h11,    1,  1, 0, 0,       2));
        tbl.push_back(mk(0, 0,  0, 0, 0,        0, 0,       1,  1, 4, 0,  1, 2, 'h22,    2,  1, 0, 0,       1));
        tbl.push_back(mk(0, 0,  0, 0, 0,        0, 0,       1,  1, 4, 0,  1, 3, 'h33,    3,  1, 0, 0,       0));
        tbl.push_back(mk(0, 0,  0, 0, 0,        0, 0,       1,  1, 4, 0,  0, 0, 0,       0,  1, 0, 0,       0));
        tbl.push_back(mk(1, 0,  0, 0, 0,        0, 0,       1,  1, 4, 0,  0, 0, 0,       0,  1, 0, 0,       1));
        tbl.push_back(mk(0, 0,  1, 4, 7,        0, 0,       1,  1, 5, 0,  0, 0, 0,       0,  1, 0, 0,       1));
        tbl.push_back(mk(1, 9,  0, 0, 0,        0, 0,       1,  1, 5, 1,  1, 0, 7,       4,  1, 0, 0,       1));
        tbl.push_back(mk(1, 32, 0, 0, 0,        0, 0,       1,  1, 6, 0,  0, 0, 0,       0,  1, 0, 0,       2));
        tbl.push_back(mk(0, 0,  1, 6, 0,        1, 'h80,    1,  1, 7, 0,  0, 0, 0,       0,  1, 0, 0,       2));
        tbl.push_back(mk(0, 0,  1, 5, 'h55,     0, 0,       1,  1, 7, 0,  0, 0, 0,       0,  1, 0, 0,       2));
        tbl.push_back(mk(0, 0,  0, 0, 0,        0, 0,       1,  1, 7, 0,  1, 9, 'h55,    5,  1, 0, 0,       1));
        tbl.push_back(mk(1, 4,  0, 0, 0,        0, 0,       1,  1, 7, 1,  0, 0, 0,       0,  0, 1, 'h80,    0));
        tbl.push_back(mk(1, 4,  1, 0, 'h99,     0, 0,       1,  0, 0, 0,  0, 0, 0,       0,  1, 0, 0,       0));
        tbl.push_back(mk(1, 6,  0, 0, 0,        0, 0,       1,  1, 0, 1,  0, 0, 0,       0,  1, 0, 0,       1));

        #12;
        chk("reset", "dp_alloc_ok", bus.dp_alloc_ok, 1);
        chk("reset", "dp_rob_index", bus.dp_rob_index, 0);
        chk("reset", "rf_dep_en", bus.rf_dep_en, 0);
        chk("reset", "rf_pre_judge", bus.rf_pre_judge, 1);
        chk("reset", "rf_commit_en", bus.rf_commit_en, 0);
        chk("reset", "rf_commit_rd", bus.rf_commit_rd, 32);
        chk("reset", "fl_en", bus.fl_en, 0);
        chk("reset", "rob_count", bus.rob_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) step(tbl[k], $sformatf("row%0d", k));

        // fill the remaining 15 slots behind entry 0 (rd 6, not ready)
        for (int i = 1; i < 16; i++)
            step(mk(1, 6'(i + 10), 0, 0, 0, 0, 0, 1, 1, 5'(i), 1, 0, 0, 0, 0, 1, 0, 0, 5'(i + 1)),
                 $sformatf("fill%0d", i));
        step(mk(1, 7, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 16), "full_refuse");
        step(mk(0, 0, 1, 0, 'habc, 0, 0, 1, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 16), "full_cdb");
        step(mk(0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 1, 6, 'habc, 0, 1, 0, 0, 15), "full_commit");
        step(mk(1, 8, 0, 0, 0,     0, 0, 1, 1, 0, 1, 0, 0, 0,     0, 1, 0, 0, 16), "wrap_alloc");
        step(mk(0, 0, 1, 1, 'h111, 0, 0, 1, 0, 1, 0, 0, 0, 0,     0, 1, 0, 0, 16), "rdy_cdb");
        for (int i = 0; i < 3; i++)
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 16), $sformatf("rdy_low%0d", i));
        step(mk(0, 0, 0, 0, 0,     0, 0, 1, 0, 1, 0, 1, 11, 'h111, 1, 1, 0, 0, 15), "rdy_commit");
        step(mk(0, 0, 0, 0, 0,     0, 0, 0, 1, 1, 0, 1, 11, 'h111, 1, 1, 0, 0, 15), "rdy_hold");
        step(mk(0, 0, 0, 0, 0,     0, 0, 1, 1, 1, 0, 0, 0, 0,     0, 1, 0, 0, 15), "rdy_resume");

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset", "rob_count", bus.rob_count, 0);
        chk("mid_reset", "dp_alloc_ok", bus.dp_alloc_ok, 1);
        chk("mid_reset", "dp_rob_index", bus.dp_rob_index, 0);
        chk("mid_reset", "rf_commit_en", bus.rf_commit_en, 0);
        chk("mid_reset", "fl_en", bus.fl_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
